// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU definitions: opcodes, FSM states, default latencies
// and the result bundle passed from e_mdu_calc to e_mdu_ctrl.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MDU_MULT = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV = 4'd3,
    MDU_DIVU = 4'd4,
    MDU_MTHI = 4'd5,
    MDU_MTLO = 4'd6
  } mdu_op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic divzero;
  } mdu_res_t;

  function automatic logic is_muldiv(
    input logic [3:0] op
  );
    return (op == MDU_MULT) ||
           (op == MDU_MULTU) ||
           (op == MDU_DIV) ||
           (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == MDU_DIV) ||
           (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit multiply and signed/unsigned divide.
// Signed divide works on magnitudes, then fixes up the signs.
module e_mdu_calc
  import e_mdu_ctrl_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output mdu_res_t    res_o
);

  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic sgn;
  logic neg_q;
  logic neg_r;
  logic bz;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) *
                  $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  assign sgn = (op_i == MDU_DIV);
  assign bz = (b_i == 32'd0);
  assign mag_a = (sgn && a_i[31]) ? -a_i : a_i;
  assign mag_b = (sgn && b_i[31]) ? -b_i : b_i;
  assign q_u = bz ? 32'd0 : mag_a / mag_b;
  assign r_u = bz ? 32'd0 : mag_a % mag_b;
  // Quotient truncates toward zero; remainder follows dividend
  assign neg_q = sgn & (a_i[31] ^ b_i[31]);
  assign neg_r = sgn & a_i[31];

  always_comb begin
    res_o = '0;
    unique case (1'b1)
      (op_i == MDU_MULT): begin
        res_o.hi = prod_s[63:32];
        res_o.lo = prod_s[31:0];
      end
      (op_i == MDU_MULTU): begin
        res_o.hi = prod_u[63:32];
        res_o.lo = prod_u[31:0];
      end
      (op_i == MDU_DIV),
      (op_i == MDU_DIVU): begin
        res_o.lo = neg_q ? -q_u : q_u;
        res_o.hi = neg_r ? -r_u : r_u;
        res_o.divzero = bz;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage mult/div controller: FSM, counter, shadow and HI/LO regs.
// Optional cancel input enabled by defining MDU_CANCEL_EN.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic        D_useMD,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] shi_q, shi_d;
  logic [31:0] slo_q, slo_d;
  logic dz_q, dz_d;
  logic cancel_w;
  mdu_res_t res;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  e_mdu_calc u_calc (
    .a_i  (A),
    .b_i  (B),
    .op_i (MDUOp),
    .res_o(res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    shi_d = shi_q;
    slo_d = slo_q;
    dz_d = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (!cancel_w) begin
          if (start && is_muldiv(MDUOp)) begin
            shi_d = res.hi;
            slo_d = res.lo;
            dz_d = res.divzero;
            cnt_d = is_div(MDUOp) ? CW'(DIV_CYCLES)
                                  : CW'(MULT_CYCLES);
            state_d = S_BUSY;
          end else if (MDUOp == MDU_MTHI) begin
            hi_d = A;
          end else if (MDUOp == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_BUSY: begin
        if (cancel_w) begin
          cnt_d = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          // Divide by zero leaves HI/LO untouched
          if (!dz_q) begin
            hi_d = shi_q;
            lo_d = slo_q;
          end
          cnt_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      shi_q <= '0;
      slo_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      shi_q <= shi_d;
      slo_q <= slo_d;
      dz_q <= dz_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign stall = D_useMD & (start | busy);
  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl with a behavioural model.
// Directed plan cases plus randomized operations.
module tb_e_mdu_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] A, B;
  logic [3:0] MDUOp;
  logic start, D_useMD;
  logic busy, stall;
  logic [31:0] HI, LO;
`ifdef MDU_CANCEL_EN
  logic cancel = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  e_mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .A      (A),
    .B      (B),
    .MDUOp  (MDUOp),
    .start  (start),
    .D_useMD(D_useMD),
    .busy   (busy),
    .stall  (stall),
    .HI     (HI),
    .LO     (LO)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op; returns busy latency
  function automatic int model(input logic [3:0] op,
                               input logic st,
                               input logic [31:0] a,
                               input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (st && op >= 4'd1 && op <= 4'd4) begin
      if (op == 4'd1) begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
        return 5;
      end
      if (op == 4'd2) begin
        p = ua * ub;
        m_hi = p[63:32];
        m_lo = p[31:0];
        return 5;
      end
      if (b != 0) begin
        if (op == 4'd3) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        m_lo = 32'(q);
        m_hi = 32'(r);
      end
      return 10;
    end
    if (op == 4'd5) m_hi = a;
    if (op == 4'd6) m_lo = a;
    return 0;
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic st,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic dmd);
    int lat, n;
    @(negedge clk);
    MDUOp = op;
    A = a;
    B = b;
    start = st;
    D_useMD = dmd;
    lat = model(op, st, a, b);
    #1;
    chk("stall_start", {63'd0, stall}, {63'd0, dmd & st});
    chk("busy_start", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
    A = $urandom;
    #1;
    n = 0;
    while (busy && n < 40) begin
      chk("stall_busy", {63'd0, stall}, {63'd0, dmd});
      n++;
      @(negedge clk);
      #1;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("stall_done", {63'd0, stall}, 64'd0);
    chk("HI", {32'd0, HI}, {32'd0, m_hi});
    chk("LO", {32'd0, LO}, {32'd0, m_lo});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  logic [31:0] edge_v [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                              32'h80000000, 32'h7FFFFFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return edge_v[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int lat;
    reset = 1'b1;
    A = '0;
    B = '0;
    MDUOp = 4'd0;
    start = 1'b0;
    D_useMD = 1'b0;
    repeat (2) @(negedge clk);
    D_useMD = 1'b1;
    start = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_HI", {32'd0, HI}, 64'd0);
    chk("rst_LO", {32'd0, LO}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    D_useMD = 1'b0;

    run_op(4'd1, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1);
    chk("mult_hi_const", {32'd0, HI}, 64'hFFFFFFFF);
    run_op(4'd2, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1);
    chk("multu_hi_const", {32'd0, HI}, 64'h1);
    run_op(4'd3, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo_const", {32'd0, LO}, 64'hFFFFFFFD);
    run_op(4'd4, 1'b1, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_const", {32'd0, LO}, 64'h3);
    run_op(4'd5, 1'b0, 32'h1234, 32'd0, 1'b1);
    run_op(4'd6, 1'b0, 32'h5678, 32'd0, 1'b1);
    run_op(4'd3, 1'b1, 32'd99, 32'd0, 1'b1);
    chk("divz_hi_const", {32'd0, HI}, 64'h1234);
    run_op(4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(4'd9, 1'b1, 32'd5, 32'd6, 1'b1);

    // mthi issued mid-operation must be ignored
    @(negedge clk);
    MDUOp = 4'd1;
    A = 32'd300;
    B = 32'd7;
    start = 1'b1;
    lat = model(4'd1, 1'b1, 32'd300, 32'd7);
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd5;
    A = 32'hDEAD;
    @(negedge clk);
    MDUOp = 4'd0;
    repeat (lat) @(negedge clk);
    #1;
    chk("mthi_busy_busy", {63'd0, busy}, 64'd0);
    chk("mthi_busy_HI", {32'd0, HI}, {32'd0, m_hi});
    chk("mthi_busy_LO", {32'd0, LO}, {32'd0, m_lo});

    // Reset in busy cycle 3 of a divide
    @(negedge clk);
    MDUOp = 4'd4;
    A = 32'd1000;
    B = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_HI", {32'd0, HI}, 64'd0);
    chk("midrst_LO", {32'd0, LO}, 64'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("midrst_nocommit", {32'd0, LO}, 64'd0);

`ifdef MDU_CANCEL_EN
    run_op(4'd5, 1'b0, 32'hAAAA, 32'd0, 1'b0);
    @(negedge clk);
    MDUOp = 4'd3;
    A = 32'd50;
    B = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_HI", {32'd0, HI}, {32'd0, m_hi});
    chk("cancel_LO", {32'd0, LO}, {32'd0, m_lo});
`endif

    for (int i = 0; i < 30; i++) begin
      logic [3:0] op;
      logic st;
      logic [31:0] b;
      op = 4'($urandom_range(0, 9));
      st = (op >= 4'd1 && op <= 4'd4) ? 1'b1 : 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      run_op(op, st, pick(), b, 1'($urandom_range(0, 1)));
    end

    do_reset();
    #1;
    chk("final_rst_HI", {32'd0, HI}, {32'd0, m_hi});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
